// File: rtl/decode_ctl_pkg.sv
// Shared opcode/field definitions and FSM encoding for the decode stage.
// Field helpers assume the 32-bit instruction layout.
package decode_ctl_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] REG_RA  = 5'd31;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_MDWAIT = 2'd2;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
  } src_pair_t;

  typedef struct packed {
    logic       wr;
    logic [4:0] rd;
  } dst_t;

  function automatic logic [4:0] f_op(input logic [31:0] ins);
    return ins[31:27];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ins);
    return ins[26:22];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ins);
    return ins[21:17];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ins);
    return ins[16:12];
  endfunction

  function automatic logic [4:0] f_aluop(input logic [31:0] ins);
    return ins[6:2];
  endfunction

  // Register operands read by an instruction; unused slots read r0.
  function automatic src_pair_t srcs_of(input logic [31:0] ins);
    src_pair_t s;
    s = '0;
    case (f_op(ins))
      OP_R:                 begin s.a = f_rs(ins); s.b = f_rt(ins); end
      OP_ADDI, OP_LW:       s.a = f_rs(ins);
      OP_SW, OP_BNE, OP_BLT: begin s.a = f_rd(ins); s.b = f_rs(ins); end
      OP_JR:                s.a = f_rd(ins);
      default:              s = '0;
    endcase
    return s;
  endfunction

  function automatic dst_t dest_of(input logic [31:0] ins);
    dst_t d;
    d = '0;
    case (f_op(ins))
      OP_R, OP_ADDI, OP_LW: begin d.wr = 1'b1; d.rd = f_rd(ins); end
      OP_JAL:               begin d.wr = 1'b1; d.rd = REG_RA; end
      default:              d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_ctl_if.sv
// Fetch/decode/execute signal bundle around the decode stage.
interface decode_ctl_if #(parameter int DW = 32);
  logic [DW-1:0] fd_ins;
  logic [DW-1:0] fd_pc;
  logic [DW-1:0] fd_j;
  logic [DW-1:0] rd_data;
  logic          br;
  logic          md_busy;
  logic [4:0]    src_a_addr;
  logic [4:0]    src_b_addr;
  logic          stall_a;
  logic          jal_jr;
  logic [DW-1:0] jal_jr_val;
  logic          jal_jr_clr;
  logic [DW-1:0] dx_ins;
  logic [DW-1:0] dx_pc;
  logic          dx_valid;

  modport master (
    output fd_ins, fd_pc, fd_j, rd_data, br, md_busy,
    input  src_a_addr, src_b_addr, stall_a, jal_jr, jal_jr_val, jal_jr_clr,
           dx_ins, dx_pc, dx_valid
  );

  modport slave (
    input  fd_ins, fd_pc, fd_j, rd_data, br, md_busy,
    output src_a_addr, src_b_addr, stall_a, jal_jr, jal_jr_val, jal_jr_clr,
           dx_ins, dx_pc, dx_valid
  );
endinterface

// File: rtl/decode_ctl_hazard_detect.sv
// Combinational hazard check of the instruction in decode against the one in D/X.
module hazard_detect
  import decode_ctl_pkg::*;
#(
  parameter int DW       = 32,
  parameter bit MD_STALL = 1'b1
) (
  input  logic [DW-1:0] cur_ins,
  input  logic [DW-1:0] dx_ins,
  input  logic          dx_valid,
  input  logic          md_busy,
  output logic          ld_use,
  output logic          jr_dep,
  output logic          md_hold,
  output logic [4:0]    src_a_addr,
  output logic [4:0]    src_b_addr
);

  logic [31:0] ci;
  logic [31:0] di;
  src_pair_t   src;
  dst_t        dst;

  assign ci = cur_ins[31:0];
  assign di = dx_ins[31:0];

  always_comb begin
    src = srcs_of(ci);
    dst = dest_of(di);
    ld_use  = dx_valid && (f_op(di) == OP_LW) && (f_rd(di) != 5'd0) &&
              ((f_rd(di) == src.a) || (f_rd(di) == src.b));
    // jr reads its target in decode, so any in-flight writer must retire first
    jr_dep  = dx_valid && (f_op(ci) == OP_JR) && dst.wr && (dst.rd == f_rd(ci));
    md_hold = MD_STALL && md_busy && (f_op(ci) == OP_R) &&
              ((f_aluop(ci) == ALU_MUL) || (f_aluop(ci) == ALU_DIV));
  end

  assign src_a_addr = src.a;
  assign src_b_addr = src.b;

endmodule

// File: rtl/decode_ctl.sv
// Decode stage: stall/replay FSM with a one-entry hold buffer, D/X register,
// and jal/jr redirect back to fetch.
module decode_ctl
  import decode_ctl_pkg::*;
#(
  parameter int DW       = 32,
  parameter bit MD_STALL = 1'b1
) (
  input logic         clock,
  input logic         clr_n,
  decode_ctl_if.slave bus
);

  typedef struct packed {
    logic [DW-1:0] ins;
    logic [DW-1:0] pc;
    logic [DW-1:0] j;
  } slot_t;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  slot_t         hold;
  slot_t         cur;
  logic [DW-1:0] dx_ins;
  logic [DW-1:0] dx_pc;
  logic          dx_valid;

  logic          ld_use;
  logic          jr_dep;
  logic          md_hold;
  logic [4:0]    src_a;
  logic [4:0]    src_b;
  logic          stall;
  logic          go;
  logic          redirect;
  logic          is_jr;
  logic          cur_nz;

  hazard_detect #(.DW(DW), .MD_STALL(MD_STALL)) u_hazard (
    .cur_ins    (cur.ins),
    .dx_ins     (dx_ins),
    .dx_valid   (dx_valid),
    .md_busy    (bus.md_busy),
    .ld_use     (ld_use),
    .jr_dep     (jr_dep),
    .md_hold    (md_hold),
    .src_a_addr (src_a),
    .src_b_addr (src_b)
  );

  // Outside RUN the held instruction owns decode; fetch is bubbling anyway.
  always_comb begin
    cur = '0;
    if (state == ST_RUN) begin
      cur.ins = bus.fd_ins;
      cur.pc  = bus.fd_pc;
      cur.j   = bus.fd_j;
    end else begin
      cur = hold;
    end
  end

  always_comb begin
    go        = clr_n && !bus.br;
    stall     = ld_use || jr_dep || md_hold;
    cur_nz    = |cur.ins;
    is_jr     = f_op(cur.ins[31:0]) == OP_JR;
    redirect  = go && !stall && (is_jr || (f_op(cur.ins[31:0]) == OP_JAL));
    state_nxt = (ld_use || jr_dep) ? ST_HOLD : ST_MDWAIT;
  end

  assign bus.stall_a    = go && stall;
  assign bus.jal_jr     = redirect;
  assign bus.jal_jr_clr = redirect;
  assign bus.jal_jr_val = !redirect ? '0 : (is_jr ? bus.rd_data : cur.j);
  assign bus.src_a_addr = clr_n ? src_a : 5'd0;
  assign bus.src_b_addr = clr_n ? src_b : 5'd0;

  // A taken branch squashes whatever decode holds, same as reset.
  always_ff @(posedge clock) begin
    if (!clr_n || bus.br) begin
      state    <= ST_RUN;
      hold     <= '0;
      dx_ins   <= '0;
      dx_pc    <= '0;
      dx_valid <= 1'b0;
    end else if (stall) begin
      state    <= state_nxt;
      hold     <= cur;
      dx_ins   <= '0;
      dx_pc    <= '0;
      dx_valid <= 1'b0;
    end else begin
      state    <= ST_RUN;
      hold     <= '0;
      dx_ins   <= cur.ins;
      dx_pc    <= cur_nz ? cur.pc : '0;
      dx_valid <= cur_nz;
    end
  end

  assign bus.dx_ins   = dx_ins;
  assign bus.dx_pc    = dx_pc;
  assign bus.dx_valid = dx_valid;

endmodule

// File: tb/tb_decode_ctl.sv
// Directed scenarios plus a randomized instruction stream checked against a
// slot-level model of load-use bubbles.
module tb_decode_ctl;

  logic clock = 1'b0;
  logic clr_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  decode_ctl_if #(.DW(32)) bus();

  decode_ctl #(.DW(32), .MD_STALL(1'b1)) dut (
    .clock (clock),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
  } obs_t;

  function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] alu);
    return {5'd0, rd, rs, rt, 5'd0, alu, 2'd0};
  endfunction

  // Does `ins` read register r (per the operand table)?
  function automatic bit reads(input logic [31:0] ins, input logic [4:0] r);
    logic [4:0] op, rd, rs, rt;
    op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
    case (op)
      5'd0:             return (rs == r) || (rt == r);
      5'd5, 5'd8:       return rs == r;
      5'd2, 5'd6, 5'd7: return (rd == r) || (rs == r);
      5'd4:             return rd == r;
      default:          return 1'b0;
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] j);
    bus.fd_ins = ins;
    bus.fd_pc  = pc;
    bus.fd_j   = j;
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 32'd0);
    bus.rd_data = 32'd0;
    bus.br      = 1'b0;
    bus.md_busy = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addi;
    addi = mk_i(5'd5, 5'd5, 5'd1, 17'd3);
    clr_n = 1'b0;
    idle();
    drive(mk_i(5'd3, 5'd0, 5'd0, 17'h40), 32'h10, 32'h40);
    bus.rd_data = 32'hdead;
    bus.md_busy = 1'b1;
    #4;
    if (bus.jal_jr !== 1'b0) begin $display("FAIL rst_jal_jr got=%0h exp=0", bus.jal_jr); n_fail++; end n_chk++;
    if (bus.jal_jr_clr !== 1'b0) begin $display("FAIL rst_jal_jr_clr got=%0h exp=0", bus.jal_jr_clr); n_fail++; end n_chk++;
    if (bus.jal_jr_val !== 32'd0) begin $display("FAIL rst_jal_jr_val got=%0h exp=0", bus.jal_jr_val); n_fail++; end n_chk++;
    if (bus.stall_a !== 1'b0) begin $display("FAIL rst_stall_a got=%0h exp=0", bus.stall_a); n_fail++; end n_chk++;
    step();
    if (bus.dx_valid !== 1'b0 || bus.dx_ins !== 32'd0 || bus.dx_pc !== 32'd0) begin
      $display("FAIL rst_dx got=%0h/%0h/%0h exp=0/0/0", bus.dx_valid, bus.dx_ins, bus.dx_pc); n_fail++;
    end n_chk++;
    clr_n = 1'b1;
    idle();
    drive(addi, 32'h5, 32'd0);
    step();
    if (bus.dx_ins !== addi || bus.dx_valid !== 1'b1) begin
      $display("FAIL rst_issue got=%0h/%0h exp=%0h/1", bus.dx_ins, bus.dx_valid, addi); n_fail++;
    end n_chk++;
    clr_n = 1'b0;
    idle();
    step();
    if (bus.dx_valid !== 1'b0 || bus.dx_ins !== 32'd0 || bus.dx_pc !== 32'd0) begin
      $display("FAIL rst_dx_clear got=%0h/%0h/%0h exp=0/0/0", bus.dx_valid, bus.dx_ins, bus.dx_pc); n_fail++;
    end n_chk++;
    clr_n = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    logic [31:0] lw, add;
    lw  = mk_i(5'd8, 5'd3, 5'd1, 17'd0);
    add = mk_r(5'd4, 5'd3, 5'd2, 5'd0);
    idle();
    drive(lw, 32'h21, 32'd0);
    #4;
    if (bus.stall_a !== 1'b0) begin $display("FAIL lu_lw_stall got=%0h exp=0", bus.stall_a); n_fail++; end n_chk++;
    step();
    drive(add, 32'h22, 32'd0);
    #4;
    if (bus.stall_a !== 1'b1) begin $display("FAIL lu_stall got=%0h exp=1", bus.stall_a); n_fail++; end n_chk++;
    if (bus.src_a_addr !== 5'd3 || bus.src_b_addr !== 5'd2) begin
      $display("FAIL lu_src got=%0d/%0d exp=3/2", bus.src_a_addr, bus.src_b_addr); n_fail++;
    end n_chk++;
    step();
    if (bus.dx_valid !== 1'b0 || bus.dx_ins !== 32'd0) begin
      $display("FAIL lu_bubble got=%0h/%0h exp=0/0", bus.dx_valid, bus.dx_ins); n_fail++;
    end n_chk++;
    idle();
    #4;
    if (bus.stall_a !== 1'b0) begin $display("FAIL lu_replay_stall got=%0h exp=0", bus.stall_a); n_fail++; end n_chk++;
    step();
    if (bus.dx_ins !== add || bus.dx_pc !== 32'h22 || bus.dx_valid !== 1'b1) begin
      $display("FAIL lu_replay got=%0h/%0h/%0h exp=%0h/22/1", bus.dx_ins, bus.dx_pc, bus.dx_valid, add); n_fail++;
    end n_chk++;
    step();
    if (bus.dx_valid !== 1'b0) begin $display("FAIL lu_no_dup got=%0h exp=0", bus.dx_valid); n_fail++; end n_chk++;
  endtask

  task automatic test_jal();
    logic [31:0] jal;
    jal = mk_i(5'd3, 5'd0, 5'd0, 17'h40);
    idle();
    drive(jal, 32'h10, 32'h40);
    #4;
    if (bus.jal_jr !== 1'b1 || bus.jal_jr_clr !== 1'b1) begin
      $display("FAIL jal_redirect got=%0h/%0h exp=1/1", bus.jal_jr, bus.jal_jr_clr); n_fail++;
    end n_chk++;
    if (bus.jal_jr_val !== 32'h40) begin $display("FAIL jal_val got=%0h exp=40", bus.jal_jr_val); n_fail++; end n_chk++;
    step();
    if (bus.dx_ins !== jal || bus.dx_pc !== 32'h10 || bus.dx_valid !== 1'b1) begin
      $display("FAIL jal_dx got=%0h/%0h/%0h exp=%0h/10/1", bus.dx_ins, bus.dx_pc, bus.dx_valid, jal); n_fail++;
    end n_chk++;
    idle();
    #4;
    if (bus.jal_jr !== 1'b0) begin $display("FAIL jal_one_shot got=%0h exp=0", bus.jal_jr); n_fail++; end n_chk++;
    step();
  endtask

  task automatic test_jr_dep();
    logic [31:0] addi, jr;
    addi = mk_i(5'd5, 5'd5, 5'd0, 17'd7);
    jr   = mk_i(5'd4, 5'd5, 5'd0, 17'd0);
    idle();
    step();
    drive(addi, 32'h20, 32'd0);
    step();
    drive(jr, 32'h21, 32'd0);
    #4;
    if (bus.stall_a !== 1'b1 || bus.jal_jr !== 1'b0) begin
      $display("FAIL jr_stall got=%0h/%0h exp=1/0", bus.stall_a, bus.jal_jr); n_fail++;
    end n_chk++;
    step();
    if (bus.dx_valid !== 1'b0) begin $display("FAIL jr_bubble got=%0h exp=0", bus.dx_valid); n_fail++; end n_chk++;
    idle();
    bus.rd_data = 32'd7;
    #4;
    if (bus.jal_jr !== 1'b1 || bus.jal_jr_clr !== 1'b1 || bus.jal_jr_val !== 32'd7) begin
      $display("FAIL jr_redirect got=%0h/%0h/%0h exp=1/1/7", bus.jal_jr, bus.jal_jr_clr, bus.jal_jr_val); n_fail++;
    end n_chk++;
    if (bus.src_a_addr !== 5'd5 || bus.stall_a !== 1'b0) begin
      $display("FAIL jr_src got=%0d/%0h exp=5/0", bus.src_a_addr, bus.stall_a); n_fail++;
    end n_chk++;
    step();
    if (bus.dx_ins !== jr || bus.dx_valid !== 1'b1) begin
      $display("FAIL jr_dx got=%0h/%0h exp=%0h/1", bus.dx_ins, bus.dx_valid, jr); n_fail++;
    end n_chk++;
    idle();
    step();
  endtask

  task automatic test_md_wait();
    logic [31:0] mul;
    int stalls;
    mul = mk_r(5'd1, 5'd2, 5'd3, 5'd6);
    stalls = 0;
    idle();
    drive(mul, 32'h30, 32'd0);
    bus.md_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #4;
      if (bus.stall_a === 1'b1) stalls++;
      step();
      if (bus.dx_valid !== 1'b0) begin $display("FAIL md_wait_bubble cyc=%0d got=%0h exp=0", k, bus.dx_valid); n_fail++; end n_chk++;
      drive(32'd0, 32'd0, 32'd0);
    end
    if (stalls !== 4) begin $display("FAIL md_stall_cycles got=%0d exp=4", stalls); n_fail++; end n_chk++;
    bus.md_busy = 1'b0;
    #4;
    if (bus.stall_a !== 1'b0) begin $display("FAIL md_release got=%0h exp=0", bus.stall_a); n_fail++; end n_chk++;
    step();
    if (bus.dx_ins !== mul || bus.dx_pc !== 32'h30 || bus.dx_valid !== 1'b1) begin
      $display("FAIL md_issue got=%0h/%0h/%0h exp=%0h/30/1", bus.dx_ins, bus.dx_pc, bus.dx_valid, mul); n_fail++;
    end n_chk++;
    idle();
    step();
  endtask

  task automatic test_br_flush();
    logic [31:0] lw, add, addi;
    lw   = mk_i(5'd8, 5'd3, 5'd1, 17'd0);
    add  = mk_r(5'd4, 5'd3, 5'd2, 5'd0);
    addi = mk_i(5'd5, 5'd6, 5'd1, 17'd1);
    idle();
    drive(lw, 32'h40, 32'd0);
    step();
    drive(add, 32'h41, 32'd0);
    step();
    idle();
    bus.br = 1'b1;
    #4;
    if (bus.stall_a !== 1'b0 || bus.jal_jr !== 1'b0 || bus.jal_jr_clr !== 1'b0) begin
      $display("FAIL br_comb got=%0h/%0h/%0h exp=0/0/0", bus.stall_a, bus.jal_jr, bus.jal_jr_clr); n_fail++;
    end n_chk++;
    step();
    if (bus.dx_valid !== 1'b0 || bus.dx_ins !== 32'd0) begin
      $display("FAIL br_bubble got=%0h/%0h exp=0/0", bus.dx_valid, bus.dx_ins); n_fail++;
    end n_chk++;
    bus.br = 1'b0;
    step();
    if (bus.dx_valid !== 1'b0) begin $display("FAIL br_discard got=%0h exp=0", bus.dx_valid); n_fail++; end n_chk++;
    drive(addi, 32'h50, 32'd0);
    step();
    if (bus.dx_ins !== addi || bus.dx_valid !== 1'b1) begin
      $display("FAIL br_resume got=%0h/%0h exp=%0h/1", bus.dx_ins, bus.dx_valid, addi); n_fail++;
    end n_chk++;
    idle();
    step();
  endtask

  task automatic test_reset_mdwait();
    logic [31:0] mul, addi;
    mul  = mk_r(5'd1, 5'd2, 5'd3, 5'd7);
    addi = mk_i(5'd5, 5'd7, 5'd1, 17'd2);
    idle();
    drive(mul, 32'h60, 32'd0);
    bus.md_busy = 1'b1;
    step();
    drive(32'd0, 32'd0, 32'd0);
    #4;
    if (bus.stall_a !== 1'b1) begin $display("FAIL rmd_waiting got=%0h exp=1", bus.stall_a); n_fail++; end n_chk++;
    clr_n = 1'b0;
    drive(mk_i(5'd3, 5'd9, 5'd9, 17'h44), 32'h61, 32'h44);
    #1;
    if (bus.stall_a !== 1'b0 || bus.jal_jr !== 1'b0 || bus.jal_jr_clr !== 1'b0 || bus.jal_jr_val !== 32'd0 ||
        bus.src_a_addr !== 5'd0 || bus.src_b_addr !== 5'd0) begin
      $display("FAIL rmd_comb_zero got=%0h/%0h/%0h/%0h/%0d/%0d exp=all 0", bus.stall_a, bus.jal_jr,
               bus.jal_jr_clr, bus.jal_jr_val, bus.src_a_addr, bus.src_b_addr); n_fail++;
    end n_chk++;
    step();
    if (bus.dx_valid !== 1'b0 || bus.dx_ins !== 32'd0 || bus.dx_pc !== 32'd0) begin
      $display("FAIL rmd_dx got=%0h/%0h/%0h exp=0/0/0", bus.dx_valid, bus.dx_ins, bus.dx_pc); n_fail++;
    end n_chk++;
    clr_n = 1'b1;
    drive(32'd0, 32'd0, 32'd0);
    #4;
    if (bus.stall_a !== 1'b0) begin $display("FAIL rmd_run got=%0h exp=0", bus.stall_a); n_fail++; end n_chk++;
    step();
    drive(addi, 32'h70, 32'd0);
    step();
    if (bus.dx_ins !== addi || bus.dx_valid !== 1'b1) begin
      $display("FAIL rmd_resume got=%0h/%0h exp=%0h/1", bus.dx_ins, bus.dx_valid, addi); n_fail++;
    end n_chk++;
    idle();
    step();
  endtask

  // Fetch model feeds a random program; each program slot lands in D/X in
  // order, with one extra bubble ahead of any load-use consumer.
  task automatic test_random_stream();
    localparam int N = 80;
    localparam logic [31:0] BASE = 32'h100;
    logic [4:0]  ops [8];
    logic [31:0] prog [N];
    obs_t        exp_q [$];
    obs_t        e;
    int idx, cyc, stalls, exp_stalls;
    bit last_stall;
    ops = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd6, 5'd7, 5'd8, 5'd8};
    for (int i = 0; i < N; i++) begin
      logic [4:0] op, rd, rs, rt;
      op = ops[$urandom_range(0, 7)];
      rd = 5'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) prog[i] = 32'd0;
      else if (op == 5'd0) prog[i] = mk_r(rd, rs, rt, 5'($urandom_range(0, 7)));
      else prog[i] = mk_i(op, rd, rs, 17'($urandom));
    end
    exp_stalls = 0;
    for (int i = 0; i < N; i++) begin
      if (i > 0 && prog[i-1][31:27] == 5'd8 && prog[i-1][26:22] != 5'd0 && reads(prog[i], prog[i-1][26:22])) begin
        exp_q.push_back('{v: 1'b0, ins: 32'd0, pc: 32'd0});
        exp_stalls++;
      end
      exp_q.push_back('{v: (prog[i] != 32'd0), ins: prog[i], pc: (prog[i] != 32'd0) ? BASE + 32'(i) + 32'd1 : 32'd0});
    end
    clr_n = 1'b0;
    idle();
    step();
    clr_n = 1'b1;
    idx = 0; cyc = 0; stalls = 0; last_stall = 1'b0;
    while ((idx < N || exp_q.size() > 0) && cyc < 3 * N + 20) begin
      if (last_stall || idx >= N) drive(32'd0, 32'd0, 32'd0);
      else begin drive(prog[idx], BASE + 32'(idx) + 32'd1, 32'd0); idx++; end
      #4;
      last_stall = (bus.stall_a === 1'b1);
      if (last_stall) stalls++;
      step();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (bus.dx_valid !== e.v || bus.dx_ins !== e.ins || bus.dx_pc !== e.pc) begin
          $display("FAIL rnd_dx cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", cyc, bus.dx_valid, bus.dx_ins,
                   bus.dx_pc, e.v, e.ins, e.pc); n_fail++;
        end n_chk++;
      end
      cyc++;
    end
    if (idx != N || exp_q.size() != 0) begin
      $display("FAIL rnd_timeout got idx=%0d left=%0d exp idx=%0d left=0", idx, exp_q.size(), N); n_fail++;
    end n_chk++;
    if (stalls != exp_stalls) begin $display("FAIL rnd_stalls got=%0d exp=%0d", stalls, exp_stalls); n_fail++; end n_chk++;
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jal();
    test_jr_dep();
    test_md_wait();
    test_br_flush();
    test_reset_mdwait();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
